// File: rtl/ahb_master_arb_if.sv
// Bus bundle for the two-master AHB-Lite arbiter.
// Carries both masters' request/control/data signals, the grants, the
// shared slave-side address/control/data bus and the slave handshake.
//   slave  : arbiter view (takes master signals and slave handshake,
//            drives grants, the muxed slave bus and data_owner)
//   master : environment view (drives master signals and slave handshake,
//            observes grants and the muxed slave bus)
interface ahb_master_arb_if;
    logic        m0_busreq;
    logic        m0_grant;
    logic [1:0]  m0_htrans;
    logic [2:0]  m0_hsize;
    logic        m0_hwrite;
    logic [31:0] m0_haddr;
    logic [31:0] m0_hwdata;

    logic        m1_busreq;
    logic        m1_grant;
    logic [1:0]  m1_htrans;
    logic [2:0]  m1_hsize;
    logic        m1_hwrite;
    logic [31:0] m1_haddr;
    logic [31:0] m1_hwdata;

    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hresp;
    logic        data_owner;

    modport slave (
        input  m0_busreq, m0_htrans, m0_hsize, m0_hwrite, m0_haddr, m0_hwdata,
        input  m1_busreq, m1_htrans, m1_hsize, m1_hwrite, m1_haddr, m1_hwdata,
        input  hready_in, hresp,
        output m0_grant, m1_grant,
        output hsel, htrans, hsize, hwrite, haddr, hwdata, data_owner
    );

    modport master (
        output m0_busreq, m0_htrans, m0_hsize, m0_hwrite, m0_haddr, m0_hwdata,
        output m1_busreq, m1_htrans, m1_hsize, m1_hwrite, m1_haddr, m1_hwdata,
        output hready_in, hresp,
        input  m0_grant, m1_grant,
        input  hsel, htrans, hsize, hwrite, haddr, hwdata, data_owner
    );
endinterface

// File: rtl/ahb_master_arb.sv
// Two-master AHB-Lite arbiter and bus mux (M0 = CPU, M1 = DMAC).
// Grants one master per address phase, muxes its address/control onto the
// shared slave bus and steers HWDATA from the owner of the data phase.
// Ports:
//   clk  - single clock
//   rst  - synchronous reset, active-high
//   bus  - ahb_master_arb_if.slave: master requests/controls/data in,
//          grants out, muxed slave bus out, hready_in/hresp in,
//          data_owner out (0 = M0, 1 = M1)
// Parameters:
//   M1_HIGH_PRIO - 1: M1 wins simultaneous requests from idle, 0: M0 wins
//   MAX_HOLD     - accepted beats an owner may keep the bus while contended
//   CW           - hold counter width, >= clog2(MAX_HOLD+1)
module ahb_master_arb #(
    parameter bit          M1_HIGH_PRIO = 1'b1,
    parameter int unsigned MAX_HOLD     = 8,
    parameter int unsigned CW           = 4
) (
    input  logic              clk,
    input  logic              rst,
    ahb_master_arb_if.slave   bus
);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    localparam logic [CW-1:0] HOLD_MAX   = CW'(MAX_HOLD);
    localparam owner_e        PRIO_OWNER = M1_HIGH_PRIO ? OWN_M1 : OWN_M0;

    owner_e        addr_owner;
    owner_e        data_owner_q;
    owner_e        other_owner;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_next;
    logic          cur_req;
    logic          oth_req;
    logic          accept;

    // An ERROR response's first cycle has hready_in=0, which already freezes
    // all state, so hresp needs no dedicated handling.
    logic unused_hresp;
    assign unused_hresp = bus.hresp;

    // Address/control mux follows the registered address owner.
    always_comb begin
        bus.htrans = bus.m0_htrans;
        bus.hsize  = bus.m0_hsize;
        bus.hwrite = bus.m0_hwrite;
        bus.haddr  = bus.m0_haddr;
        if (addr_owner == OWN_M1) begin
            bus.htrans = bus.m1_htrans;
            bus.hsize  = bus.m1_hsize;
            bus.hwrite = bus.m1_hwrite;
            bus.haddr  = bus.m1_haddr;
        end
    end

    assign bus.hsel       = bus.htrans[1];
    assign bus.hwdata     = (data_owner_q == OWN_M1) ? bus.m1_hwdata : bus.m0_hwdata;
    assign bus.m0_grant   = (addr_owner == OWN_M0);
    assign bus.m1_grant   = (addr_owner == OWN_M1);
    assign bus.data_owner = (data_owner_q == OWN_M1);

    always_comb begin
        other_owner = (addr_owner == OWN_M1) ? OWN_M0 : OWN_M1;
        cur_req     = (addr_owner == OWN_M1) ? bus.m1_busreq : bus.m0_busreq;
        oth_req     = (addr_owner == OWN_M1) ? bus.m0_busreq : bus.m1_busreq;
        accept      = bus.hready_in & bus.htrans[1];
        // Count this edge's beat before comparing against the limit so the
        // grant moves on the same edge that accepts the MAX_HOLD-th beat.
        hold_next   = hold_cnt;
        if (accept && (hold_cnt < HOLD_MAX)) begin
            hold_next = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_owner   <= OWN_M0;
            data_owner_q <= OWN_M0;
            hold_cnt     <= '0;
        end else if (bus.hready_in) begin
            if (accept) begin
                data_owner_q <= addr_owner;
            end
            if (!cur_req && !oth_req) begin
                addr_owner <= OWN_M0;
                hold_cnt   <= '0;
            end else if (oth_req && (!cur_req || (hold_next >= HOLD_MAX))) begin
                addr_owner <= other_owner;
                hold_cnt   <= '0;
            end else if (oth_req && (hold_cnt == '0) && !accept) begin
                // Contention while the owner has not started: priority decides.
                addr_owner <= PRIO_OWNER;
                hold_cnt   <= '0;
            end else begin
                hold_cnt <= hold_next;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arb.sv
// Self-checking bench for ahb_master_arb. Two instances: dut_a with M1 high
// priority (used by all scenarios) and dut_b with M0 high priority (used for
// the priority scenario only). Write data expected in a data phase is queued
// when the address phase is driven and popped when the data phase is sampled.
module tb_ahb_master_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_master_arb_if a_if ();
    ahb_master_arb_if b_if ();

    ahb_master_arb #(.M1_HIGH_PRIO(1'b1), .MAX_HOLD(8), .CW(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    ahb_master_arb #(.M1_HIGH_PRIO(1'b0), .MAX_HOLD(8), .CW(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        a_if.m0_busreq = 1'b0; a_if.m0_htrans = 2'b00; a_if.m0_hsize = 3'd2;
        a_if.m0_hwrite = 1'b0; a_if.m0_haddr = 32'h1000_0000; a_if.m0_hwdata = 32'h0BAD_0000;
        a_if.m1_busreq = 1'b0; a_if.m1_htrans = 2'b00; a_if.m1_hsize = 3'd2;
        a_if.m1_hwrite = 1'b0; a_if.m1_haddr = 32'h2000_0000; a_if.m1_hwdata = 32'h0000_0000;
        a_if.hready_in = 1'b1; a_if.hresp = 1'b0;
        b_if.m0_busreq = 1'b0; b_if.m0_htrans = 2'b00; b_if.m0_hsize = 3'd2;
        b_if.m0_hwrite = 1'b0; b_if.m0_haddr = 32'h1000_0000; b_if.m0_hwdata = 32'h0;
        b_if.m1_busreq = 1'b0; b_if.m1_htrans = 2'b00; b_if.m1_hsize = 3'd2;
        b_if.m1_hwrite = 1'b0; b_if.m1_haddr = 32'h2000_0000; b_if.m1_hwdata = 32'h0;
        b_if.hready_in = 1'b1; b_if.hresp = 1'b0;
    endtask

    task automatic test_reset();
        a_if.m0_busreq = 1'b1; a_if.m1_busreq = 1'b1; a_if.hready_in = 1'b0;
        b_if.m0_busreq = 1'b1; b_if.m1_busreq = 1'b1; b_if.hready_in = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (a_if.m0_grant !== 1'b1) begin n_errors++; $display("FAIL reset_m0_grant: got %b exp 1", a_if.m0_grant); end
        n_checks++; if (a_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL reset_m1_grant: got %b exp 0", a_if.m1_grant); end
        n_checks++; if (a_if.data_owner !== 1'b0) begin n_errors++; $display("FAIL reset_data_owner: got %b exp 0", a_if.data_owner); end
        n_checks++; if (a_if.htrans !== 2'b00) begin n_errors++; $display("FAIL reset_htrans: got %b exp 00", a_if.htrans); end
        n_checks++; if (a_if.hsel !== 1'b0) begin n_errors++; $display("FAIL reset_hsel: got %b exp 0", a_if.hsel); end
        n_checks++; if (b_if.m0_grant !== 1'b1 || b_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL reset_b_grants: got m0=%b m1=%b exp m0=1 m1=0", b_if.m0_grant, b_if.m1_grant); end
        rst = 1'b0;
        a_if.m0_busreq = 1'b0; a_if.m1_busreq = 1'b0; a_if.hready_in = 1'b1;
        b_if.m0_busreq = 1'b0; b_if.m1_busreq = 1'b0; b_if.hready_in = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        a_if.m0_busreq = 1'b1; a_if.m1_busreq = 1'b1;
        b_if.m0_busreq = 1'b1; b_if.m1_busreq = 1'b1;
        tick();
        n_checks++; if (a_if.m1_grant !== 1'b1 || a_if.m0_grant !== 1'b0) begin n_errors++; $display("FAIL prio_m1_high: got m0=%b m1=%b exp m0=0 m1=1", a_if.m0_grant, a_if.m1_grant); end
        n_checks++; if (b_if.m0_grant !== 1'b1 || b_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL prio_m0_high: got m0=%b m1=%b exp m0=1 m1=0", b_if.m0_grant, b_if.m1_grant); end
        a_if.m0_busreq = 1'b0; a_if.m1_busreq = 1'b0;
        b_if.m0_busreq = 1'b0; b_if.m1_busreq = 1'b0;
        tick();
        n_checks++; if (a_if.m0_grant !== 1'b1 || a_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL prio_park: got m0=%b m1=%b exp m0=1 m1=0", a_if.m0_grant, a_if.m1_grant); end
    endtask

    task automatic test_hold_limit();
        a_if.m1_busreq = 1'b1;
        tick();
        n_checks++; if (a_if.m1_grant !== 1'b1) begin n_errors++; $display("FAIL hold_initial_grant: got %b exp 1", a_if.m1_grant); end
        a_if.m0_busreq = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                a_if.m1_htrans = (k == 0) ? 2'b10 : 2'b11;
                a_if.m1_hwrite = 1'b1;
                a_if.m1_haddr  = 32'h2000_0000 + 32'(4 * k);
                exp_q.push_back(32'hD000_0000 + 32'(k));
            end else begin
                a_if.m1_htrans = 2'b00;
                a_if.m1_busreq = 1'b0;
                a_if.m0_htrans = 2'b10;
                a_if.m0_haddr  = 32'h1000_0040;
            end
            if (k > 0) a_if.m1_hwdata = 32'hD000_0000 + 32'(k - 1);
            a_if.m0_hwdata = 32'h0BAD_0000 + 32'(k);
            #1;
            if (k > 0) begin
                exp_v = exp_q.pop_front();
                n_checks++; if (a_if.hwdata !== exp_v) begin n_errors++; $display("FAIL hold_hwdata k=%0d: got %h exp %h", k, a_if.hwdata, exp_v); end
            end
            if (k >= 1 && k <= 7) begin
                n_checks++; if (a_if.m1_grant !== 1'b1 || a_if.m0_grant !== 1'b0) begin n_errors++; $display("FAIL hold_keep k=%0d: got m0=%b m1=%b exp m0=0 m1=1", k, a_if.m0_grant, a_if.m1_grant); end
            end
            if (k == 8) begin
                n_checks++; if (a_if.m0_grant !== 1'b1 || a_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL hold_switch: got m0=%b m1=%b exp m0=1 m1=0", a_if.m0_grant, a_if.m1_grant); end
                n_checks++; if (a_if.data_owner !== 1'b1) begin n_errors++; $display("FAIL hold_data_owner: got %b exp 1", a_if.data_owner); end
                n_checks++; if (a_if.haddr !== 32'h1000_0040) begin n_errors++; $display("FAIL hold_haddr: got %h exp 10000040", a_if.haddr); end
            end
            tick();
        end
        a_if.m0_htrans = 2'b00; a_if.m0_busreq = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        a_if.m1_busreq = 1'b1;
        tick();
        a_if.m1_htrans = 2'b10; a_if.m1_hwrite = 1'b1; a_if.m1_haddr = 32'h2000_0100;
        exp_q.push_back(32'hA5A5_0001);
        tick();
        a_if.m1_htrans = 2'b00; a_if.m1_hwdata = 32'hA5A5_0001;
        a_if.m1_busreq = 1'b0; a_if.m0_busreq = 1'b1; a_if.hready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (a_if.m1_grant !== 1'b1 || a_if.m0_grant !== 1'b0) begin n_errors++; $display("FAIL wait_grant i=%0d: got m0=%b m1=%b exp m0=0 m1=1", i, a_if.m0_grant, a_if.m1_grant); end
            n_checks++; if (a_if.hwdata !== exp_q[0]) begin n_errors++; $display("FAIL wait_hwdata i=%0d: got %h exp %h", i, a_if.hwdata, exp_q[0]); end
            tick();
        end
        a_if.hready_in = 1'b1;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (a_if.hwdata !== exp_v) begin n_errors++; $display("FAIL wait_hwdata_final: got %h exp %h", a_if.hwdata, exp_v); end
        tick();
        n_checks++; if (a_if.m0_grant !== 1'b1 || a_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL wait_handover: got m0=%b m1=%b exp m0=1 m1=0", a_if.m0_grant, a_if.m1_grant); end
        a_if.m0_busreq = 1'b0;
        tick();
    endtask

    task automatic test_release();
        a_if.m1_busreq = 1'b1;
        tick();
        a_if.m1_htrans = 2'b10; a_if.m1_hwrite = 1'b0; a_if.m1_haddr = 32'h2000_0200;
        tick();
        n_checks++; if (dut_a.hold_cnt !== 4'd1) begin n_errors++; $display("FAIL release_hold_before: got %0d exp 1", dut_a.hold_cnt); end
        a_if.m1_htrans = 2'b00; a_if.m1_busreq = 1'b0;
        tick();
        n_checks++; if (a_if.m0_grant !== 1'b1 || a_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL release_park: got m0=%b m1=%b exp m0=1 m1=0", a_if.m0_grant, a_if.m1_grant); end
        n_checks++; if (dut_a.hold_cnt !== 4'd0) begin n_errors++; $display("FAIL release_hold_cnt: got %0d exp 0", dut_a.hold_cnt); end
        n_checks++; if (a_if.hsel !== 1'b0) begin n_errors++; $display("FAIL release_hsel: got %b exp 0", a_if.hsel); end
        tick();
        n_checks++; if (a_if.hsel !== 1'b0 || a_if.m0_grant !== 1'b1) begin n_errors++; $display("FAIL release_idle: got hsel=%b m0=%b exp hsel=0 m0=1", a_if.hsel, a_if.m0_grant); end
    endtask

    task automatic test_error();
        a_if.m1_busreq = 1'b1;
        tick();
        a_if.m1_htrans = 2'b10; a_if.m1_hwrite = 1'b1; a_if.m1_haddr = 32'h2000_0300;
        a_if.m0_busreq = 1'b1;
        tick();
        a_if.m1_htrans = 2'b00; a_if.m1_busreq = 1'b0;
        a_if.hresp = 1'b1; a_if.hready_in = 1'b0;
        #1;
        n_checks++; if (a_if.m1_grant !== 1'b1) begin n_errors++; $display("FAIL error_first_cycle: got %b exp 1", a_if.m1_grant); end
        tick();
        n_checks++; if (a_if.m1_grant !== 1'b1 || a_if.m0_grant !== 1'b0) begin n_errors++; $display("FAIL error_held: got m0=%b m1=%b exp m0=0 m1=1", a_if.m0_grant, a_if.m1_grant); end
        a_if.hready_in = 1'b1;
        tick();
        n_checks++; if (a_if.m0_grant !== 1'b1 || a_if.m1_grant !== 1'b0) begin n_errors++; $display("FAIL error_handover: got m0=%b m1=%b exp m0=1 m1=0", a_if.m0_grant, a_if.m1_grant); end
        n_checks++; if (a_if.data_owner !== 1'b1) begin n_errors++; $display("FAIL error_data_owner: got %b exp 1", a_if.data_owner); end
        a_if.hresp = 1'b0; a_if.m0_busreq = 1'b0;
        tick();
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_priority();
        test_hold_limit();
        test_wait_states();
        test_release();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
